timer_button_ctrl: RTL and testbench
====================================

// Module: timer_button_ctrl
// PURPOSE
//   Front-end control stage for stop_timer. It turns raw, bouncing, asynchronous push-buttons
//   into clean single-cycle start/stop command pulses.
//   Sync -> debounce -> rising-edge detect per button, then a run/idle FSM that only issues legal commands.
//   start/stop drive stop_timer.start/stop directly; running feeds status LEDs.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive cycles a synced level must hold before the debounced state changes (>=2)
//   DB_CNT_W         8   debounce counter width; must satisfy 2**DB_CNT_W > DEBOUNCE_CYCLES
//   SYNC_STAGES      2   synchroniser flops per raw button input (>=2)
// PORTS
//   clk            in   1  system clock, all logic on rising edge
//   rst            in   1  asynchronous, active-high reset
//   btn_start_raw  in   1  raw start button, async, active-high, may bounce
//   btn_stop_raw   in   1  raw stop button, async, active-high, may bounce
//   btn_clear_raw  in   1  raw clear button (present only with CLEAR_BTN_EN)
//   start          out  1  one-cycle command pulse to stop_timer.start
//   stop           out  1  one-cycle command pulse to stop_timer.stop
//   clear          out  1  one-cycle clear pulse (present only with CLEAR_BTN_EN)
//   running        out  1  1 while FSM is in RUN
// BEHAVIOUR
//   Reset: sync flops, debounced states, counters, start, stop, clear and running all = 0; FSM = IDLE.
//     Deassertion is used as-is; no internal reset sync.
//   Debounce, per button: cnt counts cycles with synced != db_state and clears to 0 whenever they are equal.
//     When synced != db_state and cnt == DEBOUNCE_CYCLES-1, db_state flips and cnt returns to 0.
//     A pulse shorter than DEBOUNCE_CYCLES synced cycles never changes db_state.
//   Press event: db_state 0->1 only. Releases (1->0) produce no event.
//     A button held through reset release yields exactly one press.
//   Latency: the output pulse is high in the cycle after the edge that sets db_state = 1.
//     That is SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples the new raw level.
//   FSM states: IDLE, RUN.
//     IDLE + start press -> start=1 for one cycle; go to RUN.
//     IDLE + stop press -> ignored.
//     RUN + stop press -> stop=1 for one cycle; go to IDLE.
//     RUN + start press -> ignored.
//   Simultaneous events in the same cycle: only the command legal in the current state acts.
//     Therefore stop wins in RUN and start wins in IDLE. At most one output pulse per cycle.
//   start and stop are registered outputs and are never high together. Every pulse is exactly 1 cycle wide.
//   running = (state == RUN), registered, and changes in the same cycle the start/stop pulse is high.
//   Reset mid-debounce or mid-pulse: everything returns to reset values immediately. No pulse is issued afterwards.
// CONFIGURATION
//   CLEAR_BTN_EN defined:
//     adds btn_clear_raw and clear with the same sync/debounce path.
//     In IDLE a clear press gives clear=1 for one cycle. In RUN it is ignored.
//     If clear and start are pressed in the same IDLE cycle, start wins and clear is dropped.
//   CLEAR_BTN_EN undefined:
//     btn_clear_raw and clear do not exist and no clear logic is built.
//     All other behaviour is identical.
// STRUCTURE
//   Shared package/header timer_ctrl_pkg:
//     FSM state encoding ST_IDLE=1'b0, ST_RUN=1'b1.
//     Default DEBOUNCE_CYCLES and SYNC_STAGES constants, shared with stop_timer benches.
//   Sub-module btn_debounce (synchroniser + debounce counter + rising-edge detector).
//     Params SYNC_STAGES, DEBOUNCE_CYCLES, DB_CNT_W. Outputs db_level and press (1-cycle).
//     Instanced once per button.
//   Top level holds the FSM, output registers and the CLEAR_BTN_EN conditional.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 20 ns clk)
//   1 Reset: rst=1 for 3 cycles, then 0, buttons low for 50 cycles
//     -> start=stop=clear=running=0 throughout.
//   2 Clean start: btn_start_raw=1 held 12 cycles
//     -> exactly one start pulse, 1 cycle wide, 7 edges after the first sampling edge; running=1 from that cycle.
//   3 Bounce: btn_start_raw toggles 1,0,1,0 every 2 cycles, then holds 1 for 10 cycles
//     -> exactly one start pulse. Release with bounce -> no pulse.
//   4 Glitch in RUN: btn_stop_raw=1 for 3 cycles
//     -> no stop pulse, running stays 1. Then hold 8 cycles -> one stop pulse, running=0.
//   5 Simultaneous: both buttons rise on the same edge in RUN
//     -> only stop pulses, running=0. Repeat in IDLE -> only start pulses, running=1.
//   6 Reset mid-debounce: btn_start_raw=1, rst pulsed 2 cycles after the change, button kept high
//     -> no pulse before reset. One start pulse 7 edges after rst drops.
//     With CLEAR_BTN_EN: clear press in IDLE -> one clear pulse; in RUN -> none.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared FSM encoding and default timing constants for the timer control front-end
package timer_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_DB_CNT_W        = 8;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debounce counter and press (rising-edge) detector
module btn_debounce
  import timer_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_CNT_W        = DEF_DB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db_level,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_CNT_W-1:0]    cnt;
  logic                   db_state;
  logic                   db_prev;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt      <= '0;
      db_state <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      db_prev <= db_state;
      // Any cycle where the synced level agrees with db_state restarts the hold count.
      if (synced == db_state) begin
        cnt <= '0;
      end else if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_state <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

  assign db_level = db_state;
  assign press    = db_state & ~db_prev;

endmodule

// File: rtl/timer_button_ctrl.sv
// rtl/timer_button_ctrl.sv - debounced buttons to start/stop command pulses via an IDLE/RUN FSM
// Optional clear button path built only when CLEAR_BTN_EN is defined.
module timer_button_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_CNT_W        = DEF_DB_CNT_W,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start_raw,
  input  logic btn_stop_raw,
`ifdef CLEAR_BTN_EN
  input  logic btn_clear_raw,
  output logic clear,
`endif
  output logic start,
  output logic stop,
  output logic running
);

  state_t state;
  logic   start_press;
  logic   stop_press;
  logic   start_level_unused;
  logic   stop_level_unused;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_db_start (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_start_raw),
    .db_level(start_level_unused),
    .press   (start_press)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_db_stop (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_stop_raw),
    .db_level(stop_level_unused),
    .press   (stop_press)
  );

`ifdef CLEAR_BTN_EN
  logic clear_press;
  logic clear_level_unused;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_clear_raw),
    .db_level(clear_level_unused),
    .press   (clear_press)
  );
`endif

  // Only the command legal in the current state is acted on, so at most one pulse per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      start   <= 1'b0;
      stop    <= 1'b0;
      running <= 1'b0;
`ifdef CLEAR_BTN_EN
      clear   <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
`ifdef CLEAR_BTN_EN
      clear <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start_press) begin
            state   <= ST_RUN;
            start   <= 1'b1;
            running <= 1'b1;
          end
`ifdef CLEAR_BTN_EN
          else if (clear_press) begin
            clear <= 1'b1;
          end
`endif
        end
        ST_RUN: begin
          if (stop_press) begin
            state   <= ST_IDLE;
            stop    <= 1'b1;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_button_ctrl.sv
// tb/tb_timer_button_ctrl.sv - scoreboard bench for timer_button_ctrl against a sample-window reference model
module tb_timer_button_ctrl;

  localparam int DB = 4;
  localparam int SS = 2;
  localparam int HL = SS + DB;
`ifdef CLEAR_BTN_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bs = 1'b0;
  logic bp = 1'b0;
  logic bc = 1'b0;
  logic start, stop, clear, running;

  always #10 clk = ~clk;

  timer_button_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DB_CNT_W       (8),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start_raw(bs),
    .btn_stop_raw (bp),
`ifdef CLEAR_BTN_EN
    .btn_clear_raw(bc),
    .clear        (clear),
`endif
    .start        (start),
    .stop         (stop),
    .running      (running)
  );

`ifndef CLEAR_BTN_EN
  assign clear = 1'b0;
`endif

  typedef struct {
    int       cyc;
    logic [3:0] v;  // {start, stop, clear, running}
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference: a button's debounced level flips once the last DB synced samples
  // (raw samples delayed by SS edges) all differ from it.
  logic [HL-1:0] h [3];
  bit db [3];
  bit prs [3];
  bit m_run;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      h[b]   = '0;
      db[b]  = 1'b0;
      prs[b] = 1'b0;
    end
    m_run = 1'b0;
  endtask

  initial model_reset();

  always @(posedge rst) begin
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].v = 4'b0000;
  end

  always @(posedge clk) begin
    logic [3:0] e;
    logic [2:0] rw;
    bit newdb;
    exp_t x;
    cyc++;
    e = 4'b0000;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_run && prs[0]) begin
        m_run = 1'b1;
        e[3] = 1'b1;
      end else if (m_run && prs[1]) begin
        m_run = 1'b0;
        e[2] = 1'b1;
      end else if (!m_run && prs[2] && CLR) begin
        e[1] = 1'b1;
      end
      e[0] = m_run;
      rw = {bc, bp, bs};
      for (int b = 0; b < 3; b++) begin
        h[b] = {h[b][HL-2:0], rw[b]};
        newdb = db[b];
        if (db[b] == 1'b0 && (&h[b][HL-1:SS])) newdb = 1'b1;
        if (db[b] == 1'b1 && (h[b][HL-1:SS] == '0)) newdb = 1'b0;
        prs[b] = newdb & ~db[b];
        db[b] = newdb;
      end
    end
    x.cyc = cyc;
    x.v = e;
    exp_q.push_back(x);
  end

  always @(negedge clk) begin
    exp_t x;
    logic [3:0] got;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      got = {start, stop, clear, running};
      vectors++;
      if (got !== x.v) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d start/stop/clear/running got=%b expected=%b", x.cyc, got, x.v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Raw start must be applied just before calling; counts edges until start shows.
  task automatic check_latency(input string name, input int hold);
    int lat;
    lat = 0;
    for (int k = 1; k <= hold; k++) begin
      tick(1);
      if (start && lat == 0) lat = k;
    end
    vectors++;
    if (lat != SS + DB + 1) begin
      miscompares++;
      $display("FAIL %s latency got=%0d expected=%0d", name, lat, SS + DB + 1);
    end
  endtask

  task automatic press(input int which, input int len);
    if (which == 0) bs = 1'b1;
    if (which == 1) bp = 1'b1;
    if (which == 2) bc = 1'b1;
    tick(len);
    bs = 1'b0;
    bp = 1'b0;
    bc = 1'b0;
    tick(10);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(50);

    bs = 1'b1;
    check_latency("clean_start", 12);
    bs = 1'b0;
    tick(12);

    press(1, 10);
    for (int i = 0; i < 4; i++) begin
      bs = ~bs;
      tick(2);
    end
    bs = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      bs = ~bs;
      tick(2);
    end
    bs = 1'b0;
    tick(10);

    press(1, 3);
    press(1, 8);

    press(0, 8);
    bs = 1'b1;
    bp = 1'b1;
    tick(8);
    bs = 1'b0;
    bp = 1'b0;
    tick(10);
    bs = 1'b1;
    bp = 1'b1;
    tick(8);
    bs = 1'b0;
    bp = 1'b0;
    tick(10);
    press(1, 8);

    bs = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_latency("reset_mid_debounce", 12);
    bs = 1'b0;
    tick(10);
    press(1, 8);

    if (CLR) begin
      press(2, 8);
      press(0, 8);
      press(2, 8);
      press(1, 8);
      bs = 1'b1;
      bc = 1'b1;
      tick(8);
      bs = 1'b0;
      bc = 1'b0;
      tick(10);
      press(1, 8);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bs = ~bs;
      if ($urandom_range(0, 5) == 0) bp = ~bp;
      if ($urandom_range(0, 5) == 0) bc = ~bc;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
      tick(1);
    end

    bs = 1'b0;
    bp = 1'b0;
    bc = 1'b0;
    tick(30);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
